// File: rtl/clk_gen_pkg.sv
// Shared types and arithmetic for the period clock generator.
// The phase split is done at 32 bits and truncated by the caller to its counter width.
package clk_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } gen_state_e;

  typedef struct packed {
    logic [31:0] high;
    logic [31:0] low;
  } phase_len_t;

  // Counter width that holds period*unit_cycles without overflow.
  function automatic int cnt_width(input int pw, input int unit_cycles);
    return pw + $clog2(unit_cycles) + 1;
  endfunction

  // The high phase takes the odd cycle, so a one-cycle period is all high.
  function automatic phase_len_t split_period(input logic [31:0] total);
    phase_len_t r;
    r.low  = total >> 1;
    r.high = total - r.low;
    return r;
  endfunction

endpackage

// File: rtl/period_load_reg.sv
// Pending-period register with the load handshake.
// A zero period is rejected; a new load wins over a consume in the same cycle.
module period_load_reg #(
  parameter int PW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [PW-1:0] period_i,
  input  logic          consume_i,
  output logic [PW-1:0] pending_o,
  output logic          pending_valid_o,
  output logic          load_ack_o,
  output logic          period_err_o
);

  logic [PW-1:0] pending_q, pending_d;
  logic          valid_q, valid_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          load_ok;

  assign load_ok = load_i && (period_i != '0);

  always_comb begin
    pending_d = pending_q;
    valid_d   = valid_q;
    ack_d     = load_ok;
    err_d     = load_i && (period_i == '0);
    if (load_ok) begin
      pending_d = period_i;
      valid_d   = 1'b1;
    end else if (consume_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign pending_o       = pending_q;
  assign pending_valid_o = valid_q;
  assign load_ack_o      = ack_q;
  assign period_err_o    = err_q;

endmodule

// File: rtl/period_clock_gen.sv
// Programmable-period test clock source; period changes land only on period boundaries.
//   state | meaning
//   IDLE  | stopped, clk_ex low, waiting for en
//   HIGH  | clk_ex high, counting down the high phase
//   LOW   | clk_ex low, counting down the low phase; last cycle is the period boundary
module period_clock_gen
  import clk_gen_pkg::*;
#(
  parameter int PW             = 8,
  parameter int UNIT_CYCLES    = 6,
  parameter int DEFAULT_PERIOD = 100
) (
  input  logic          clk50,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic [PW-1:0] period_in,
  output logic          load_ack,
  output logic          period_err,
  output logic          clk_ex,
  output logic          rise_pulse,
  output logic          busy,
  output logic [PW-1:0] period_active
);

  localparam int            CW         = cnt_width(PW, UNIT_CYCLES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [PW-1:0] PERIOD_RST = PW'(DEFAULT_PERIOD);

  gen_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] low_q, low_d;
  logic [PW-1:0] active_q, active_d;
  logic          clk_ex_q, clk_ex_d;
  logic          rise_q, rise_d;
  logic          busy_q;

  logic [PW-1:0] pend_val;
  logic          pend_valid;
  logic          consume;
  logic          start;
  logic          boundary;
  logic [PW-1:0] next_period;
  logic [CW-1:0] t_next;
  phase_len_t    ph_next;

  period_load_reg #(.PW(PW)) u_load_reg (
    .clk_i           (clk50),
    .rst_i           (rst),
    .load_i          (load),
    .period_i        (period_in),
    .consume_i       (consume),
    .pending_o       (pend_val),
    .pending_valid_o (pend_valid),
    .load_ack_o      (load_ack),
    .period_err_o    (period_err)
  );

  assign next_period = pend_valid ? pend_val : active_q;
  assign t_next      = CW'(next_period) * CW'(UNIT_CYCLES);
  assign ph_next     = split_period(32'(t_next));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    low_d    = low_q;
    active_d = active_q;
    clk_ex_d = clk_ex_q;
    rise_d   = 1'b0;
    consume  = 1'b0;
    start    = 1'b0;
    boundary = 1'b0;

    case (state_q)
      IDLE: begin
        clk_ex_d = 1'b0;
        cnt_d    = '0;
        start    = en;
      end
      HIGH: begin
        if (cnt_q > CNT_ONE) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (low_q != '0) begin
          state_d  = LOW;
          cnt_d    = low_q;
          clk_ex_d = 1'b0;
        end else begin
          boundary = 1'b1;
        end
      end
      LOW: begin
        if (cnt_q > CNT_ONE) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          boundary = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        clk_ex_d = 1'b0;
        cnt_d    = '0;
      end
    endcase

    if (boundary) begin
      if (en) begin
        start = 1'b1;
      end else begin
        state_d  = IDLE;
        clk_ex_d = 1'b0;
        cnt_d    = '0;
      end
    end

    // Phase lengths are latched here so a later load cannot reshape a running period.
    if (start) begin
      state_d  = HIGH;
      cnt_d    = CW'(ph_next.high);
      low_d    = CW'(ph_next.low);
      clk_ex_d = 1'b1;
      rise_d   = 1'b1;
      active_d = next_period;
      consume  = pend_valid;
    end
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      low_q    <= '0;
      active_q <= PERIOD_RST;
      clk_ex_q <= 1'b0;
      rise_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      low_q    <= low_d;
      active_q <= active_d;
      clk_ex_q <= clk_ex_d;
      rise_q   <= rise_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign clk_ex        = clk_ex_q;
  assign rise_pulse    = rise_q;
  assign busy          = busy_q;
  assign period_active = active_q;

endmodule

// File: tb/tb_period_clock_gen.sv
// Directed bench for period_clock_gen (UNIT_CYCLES=6, DEFAULT_PERIOD=100).
// Inputs change and outputs are sampled on the falling edge of clk50.
module tb_period_clock_gen;

  logic       clk50 = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic [7:0] period_in;
  logic       load_ack;
  logic       period_err;
  logic       clk_ex;
  logic       rise_pulse;
  logic       busy;
  logic [7:0] period_active;

  int n_assert = 0;
  int n_fail   = 0;

  period_clock_gen #(
    .PW             (8),
    .UNIT_CYCLES    (6),
    .DEFAULT_PERIOD (100)
  ) dut (
    .clk50         (clk50),
    .rst           (rst),
    .en            (en),
    .load          (load),
    .period_in     (period_in),
    .load_ack      (load_ack),
    .period_err    (period_err),
    .clk_ex        (clk_ex),
    .rise_pulse    (rise_pulse),
    .busy          (busy),
    .period_active (period_active)
  );

  always #10 clk50 = ~clk50;

  task automatic chk(input string tag, input int observed, input int expected);
    n_assert++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  // Called on the falling edge where rise_pulse is seen; returns on the next one.
  task automatic measure_period(output int hi, output int lo);
    hi = 1;
    lo = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk50);
      if (rise_pulse) return;
      if (clk_ex) hi++;
      else lo++;
    end
  endtask

  task automatic wait_rise(output int cycles);
    cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk50);
      cycles++;
      if (rise_pulse) return;
    end
    cycles = -1;
  endtask

  int hi, lo, cyc, ones;

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; period_in = 8'd0;

    // 1: reset state, then free run at the default period
    repeat (3) @(negedge clk50);
    chk("rst_clk_ex", clk_ex, 0);
    chk("rst_rise", rise_pulse, 0);
    chk("rst_ack", load_ack, 0);
    chk("rst_err", period_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_active", period_active, 100);
    rst = 1'b0;
    @(negedge clk50);
    chk("idle_no_en_busy", busy, 0);
    chk("idle_no_en_clk", clk_ex, 0);
    en = 1'b1;
    @(negedge clk50);
    chk("start_rise", rise_pulse, 1);
    chk("start_clk", clk_ex, 1);
    chk("start_busy", busy, 1);
    measure_period(hi, lo);
    chk("p100_high", hi, 300);
    chk("p100_low", lo, 300);
    chk("p100_active", period_active, 100);

    // 2: load 10 at cycle 50 of the high phase
    repeat (49) @(negedge clk50);
    load = 1'b1; period_in = 8'd10;
    @(negedge clk50);
    chk("ld10_ack", load_ack, 1);
    chk("ld10_err", period_err, 0);
    chk("ld10_active_kept", period_active, 100);
    load = 1'b0;
    @(negedge clk50);
    chk("ld10_ack_pulse", load_ack, 0);
    wait_rise(cyc);
    chk("ld10_rest_of_period", cyc, 549);
    chk("ld10_adopted", period_active, 10);
    measure_period(hi, lo);
    chk("p10_high", hi, 30);
    chk("p10_low", lo, 30);

    // 3: zero period is rejected
    load = 1'b1; period_in = 8'd0;
    @(negedge clk50);
    chk("ld0_err", period_err, 1);
    chk("ld0_ack", load_ack, 0);
    load = 1'b0;
    @(negedge clk50);
    chk("ld0_err_pulse", period_err, 0);
    wait_rise(cyc);
    chk("ld0_active", period_active, 10);
    measure_period(hi, lo);
    chk("ld0_high", hi, 30);
    chk("ld0_low", lo, 30);

    // 4: load on the boundary cycle while 10 is pending
    load = 1'b1; period_in = 8'd10;
    @(negedge clk50);
    chk("ld10b_ack", load_ack, 1);
    load = 1'b0;
    repeat (58) @(negedge clk50);
    load = 1'b1; period_in = 8'd20;
    @(negedge clk50);
    chk("bnd_rise", rise_pulse, 1);
    chk("bnd_ack", load_ack, 1);
    chk("bnd_active_old", period_active, 10);
    load = 1'b0;
    measure_period(hi, lo);
    chk("bnd_next_total", hi + lo, 60);
    chk("bnd_after_active", period_active, 20);
    measure_period(hi, lo);
    chk("p20_high", hi, 60);
    chk("p20_low", lo, 60);

    // 5: en dropped 5 cycles into a P=10 high phase
    load = 1'b1; period_in = 8'd10;
    @(negedge clk50);
    load = 1'b0;
    wait_rise(cyc);
    chk("en_setup_active", period_active, 10);
    hi = 0; lo = 0;
    for (int i = 0; i < 4; i++) begin
      if (clk_ex) hi++;
      else lo++;
      @(negedge clk50);
    end
    if (clk_ex) hi++;
    else lo++;
    en = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk50);
      if (!busy) break;
      if (clk_ex) hi++;
      else lo++;
    end
    chk("en_off_high", hi, 30);
    chk("en_off_low", lo, 30);
    chk("en_off_busy", busy, 0);
    chk("en_off_clk", clk_ex, 0);
    ones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk50);
      if (clk_ex || rise_pulse || busy) ones++;
    end
    chk("idle_quiet", ones, 0);
    en = 1'b1;
    @(negedge clk50);
    chk("re_en_rise", rise_pulse, 1);
    chk("re_en_active", period_active, 10);

    // 6: reset mid-LOW with a pending value, load held during reset
    load = 1'b1; period_in = 8'd50;
    @(negedge clk50);
    chk("ld50_ack", load_ack, 1);
    load = 1'b0;
    repeat (39) @(negedge clk50);
    chk("pre_rst_low", clk_ex, 0);
    rst = 1'b1; load = 1'b1; period_in = 8'd7;
    @(negedge clk50);
    chk("mid_rst_clk", clk_ex, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_active", period_active, 100);
    chk("mid_rst_ack", load_ack, 0);
    rst = 1'b0; load = 1'b0;
    @(negedge clk50);
    chk("post_rst_rise", rise_pulse, 1);
    chk("post_rst_active", period_active, 100);
    measure_period(hi, lo);
    chk("post_rst_high", hi, 300);
    chk("post_rst_low", lo, 300);
    chk("post_rst_no_stale", period_active, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
